// File: rtl/year_bcd_counter_if.sv
// Year counter bus: control/load inputs and
// binary, BCD, 7-segment and status outputs.
interface year_bcd_counter_if #(
   parameter int DIGITS   = 4,
   parameter int BIN_BITS = 14
);
   logic                  carry_in;
   logic                  set;
   logic [DIGITS-1:0]     up;
   logic                  load;
   logic [4*DIGITS-1:0]   load_bcd;
   logic [BIN_BITS-1:0]   year_count;
   logic [4*DIGITS-1:0]   year_bcd;
   logic [7*DIGITS-1:0]   year_7seg;
   logic                  leap;
   logic                  carry_out;
   logic                  load_err;

   modport master (
      output carry_in, set, up, load, load_bcd,
      input  year_count, year_bcd, year_7seg,
      input  leap, carry_out, load_err
   );

   modport slave (
      input  carry_in, set, up, load, load_bcd,
      output year_count, year_bcd, year_7seg,
      output leap, carry_out, load_err
   );
endinterface

// File: rtl/year_bcd_counter.sv
// BCD year counter with range wrap, per-digit
// set-mode adjust, validated load and leap flag.
module year_bcd_counter #(
   parameter int DIGITS     = 4,
   parameter int BIN_BITS   = 14,
   parameter int YEAR_MIN   = 1800,
   parameter int YEAR_MAX   = 2199,
   parameter int YEAR_RESET = 1801
) (
   input  logic clock,
   input  logic reset,
   year_bcd_counter_if.slave bus
);
   localparam int W = 4 * DIGITS;

   function automatic logic [W-1:0] to_bcd(input int unsigned v);
      logic [W-1:0] r;
      int unsigned  t;
      r = '0;
      t = v;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i+:4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic int unsigned to_bin(input logic [W-1:0] b);
      int unsigned acc;
      acc = 0;
      for (int i = DIGITS - 1; i >= 0; i--)
         acc = acc * 10 + 32'(b[4*i+:4]);
      return acc;
   endfunction

   function automatic logic digits_ok(input logic [W-1:0] b);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < DIGITS; i++)
         if (b[4*i+:4] > 4'd9) ok = 1'b0;
      return ok;
   endfunction

   function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] b);
      logic [W-1:0] r;
      logic         c;
      r = b;
      c = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (c) begin
            if (r[4*i+:4] == 4'd9) begin
               r[4*i+:4] = 4'd0;
            end else begin
               r[4*i+:4] = r[4*i+:4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h00;
      endcase
      return s;
   endfunction

   localparam int unsigned MIN_U = YEAR_MIN;
   localparam int unsigned MAX_U = YEAR_MAX;
   localparam logic [W-1:0] MIN_BCD = to_bcd(YEAR_MIN);
   localparam logic [W-1:0] RST_BCD = to_bcd(YEAR_RESET);

   logic [W-1:0]      bcd_q, bcd_d;
   logic [DIGITS-1:0] up_q;
   logic              cout_q, cout_d;
   logic              lerr_q, lerr_d;
   logic [DIGITS-1:0] rise;
   logic [W-1:0]      cand;
   int unsigned       year_u;
   int unsigned       cand_u;
   int unsigned       load_u;

   assign rise   = bus.up & ~up_q;
   assign year_u = to_bin(bcd_q);
   assign load_u = to_bin(bus.load_bcd);
   assign cand_u = to_bin(cand);

   // Set-mode candidate: each rising digit steps mod 10, no carry
   always_comb begin
      cand = bcd_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (rise[i])
            cand[4*i+:4] = (bcd_q[4*i+:4] == 4'd9) ? 4'd0
                                                   : bcd_q[4*i+:4] + 4'd1;
      end
   end

   // Next state: load > set-mode adjust > carry increment
   always_comb begin
      bcd_d  = bcd_q;
      cout_d = 1'b0;
      lerr_d = 1'b0;
      if (bus.load) begin
         if (digits_ok(bus.load_bcd) &&
             load_u >= MIN_U && load_u <= MAX_U)
            bcd_d = bus.load_bcd;
         else
            lerr_d = 1'b1;
      end else if (bus.set) begin
         if (|rise) begin
            if (cand_u >= MIN_U && cand_u <= MAX_U)
               bcd_d = cand;
            else
               bcd_d = MIN_BCD;
         end
      end else if (bus.carry_in) begin
         if (year_u == MAX_U) begin
            bcd_d  = MIN_BCD;
            cout_d = 1'b1;
         end else begin
            bcd_d = bcd_inc(bcd_q);
         end
      end
   end

   // State registers; up_q preset high so held buttons give no edge
   always_ff @(posedge clock) begin
      if (!reset) begin
         bcd_q  <= RST_BCD;
         up_q   <= '1;
         cout_q <= 1'b0;
         lerr_q <= 1'b0;
      end else begin
         bcd_q  <= bcd_d;
         up_q   <= bus.up;
         cout_q <= cout_d;
         lerr_q <= lerr_d;
      end
   end

   logic [15:0]  ext;
   int unsigned  lo, hi;
   logic         div4, div100, div400;
   logic [7*DIGITS-1:0] seg;

   assign ext = 16'(bcd_q);

   // Leap flag from the low and high digit pairs
   always_comb begin
      lo     = 32'(ext[7:4]) * 10 + 32'(ext[3:0]);
      hi     = 32'(ext[15:12]) * 10 + 32'(ext[11:8]);
      div4   = (lo % 4) == 0;
      div100 = (lo == 0);
      div400 = div100 && ((hi % 4) == 0);
   end

   // Per-digit 7-segment decode
   always_comb begin
      seg = '0;
      for (int i = 0; i < DIGITS; i++)
         seg[7*i+:7] = seg7(bcd_q[4*i+:4]);
   end

   assign bus.year_count = BIN_BITS'(year_u);
   assign bus.year_bcd   = bcd_q;
   assign bus.year_7seg  = seg;
   assign bus.leap       = div4 & (~div100 | div400);
   assign bus.carry_out  = cout_q;
   assign bus.load_err   = lerr_q;
endmodule

// File: tb/tb_year_bcd_counter.sv
// Scoreboard bench for year_bcd_counter with an
// integer-year reference model and random stimulus.
module tb_year_bcd_counter;
   localparam int YMIN = 1800;
   localparam int YMAX = 2199;
   localparam int YRST = 1801;

   typedef struct {
      int   year;
      logic cout;
      logic lerr;
   } exp_t;

   logic clk;
   logic rst_n;
   exp_t sbq[$];
   int   total;
   int   bad;
   int   my;
   logic [3:0] mprev;

   year_bcd_counter_if #(.DIGITS(4), .BIN_BITS(14)) bus ();

   year_bcd_counter #(
      .DIGITS(4), .BIN_BITS(14),
      .YEAR_MIN(YMIN), .YEAR_MAX(YMAX), .YEAR_RESET(YRST)
   ) dut (
      .clock(clk),
      .reset(rst_n),
      .bus(bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int dig(input int y, input int i);
      return (y / (10 ** i)) % 10;
   endfunction

   function automatic logic [15:0] ybcd(input int y);
      logic [15:0] r;
      for (int i = 0; i < 4; i++) r[4*i+:4] = 4'(dig(y, i));
      return r;
   endfunction

   function automatic logic [27:0] yseg(input int y);
      logic [6:0] tbl [10];
      logic [27:0] r;
      tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
      for (int i = 0; i < 4; i++) r[7*i+:7] = tbl[dig(y, i)];
      return r;
   endfunction

   function automatic logic is_leap(input int y);
      return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
   endfunction

   task automatic chk(input string n, input logic [31:0] a,
                      input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s got=%h want=%h t=%0t", n, a, e, $time);
      end
   endtask

   // Drive one cycle of inputs and push the model's prediction
   task automatic step(input logic rn, input logic cin, input logic st,
                       input logic [3:0] u, input logic ld,
                       input logic [15:0] lb);
      exp_t e;
      logic [3:0] rise;
      int v, c;
      logic ok;
      @(negedge clk);
      rst_n = rn;
      bus.carry_in = cin;
      bus.set = st;
      bus.up = u;
      bus.load = ld;
      bus.load_bcd = lb;
      e.cout = 1'b0;
      e.lerr = 1'b0;
      if (!rn) begin
         my = YRST;
         mprev = 4'hF;
      end else begin
         rise = u & ~mprev;
         if (ld) begin
            ok = 1'b1;
            v = 0;
            for (int i = 3; i >= 0; i--) begin
               if (lb[4*i+:4] > 9) ok = 1'b0;
               v = v * 10 + int'(lb[4*i+:4]);
            end
            if (ok && v >= YMIN && v <= YMAX) my = v;
            else e.lerr = 1'b1;
         end else if (st) begin
            if (rise != 0) begin
               c = 0;
               for (int i = 3; i >= 0; i--) begin
                  v = dig(my, i);
                  if (rise[i]) v = (v + 1) % 10;
                  c = c * 10 + v;
               end
               my = (c >= YMIN && c <= YMAX) ? c : YMIN;
            end
         end else if (cin) begin
            if (my == YMAX) begin
               my = YMIN;
               e.cout = 1'b1;
            end else begin
               my = my + 1;
            end
         end
         mprev = u;
      end
      e.year = my;
      sbq.push_back(e);
   endtask

   // Monitor: every cycle the DUT presents a new year state
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sbq.size() != 0) begin
         e = sbq.pop_front();
         chk("year_count", 32'(bus.year_count), 32'(e.year));
         chk("year_bcd", 32'(bus.year_bcd), 32'(ybcd(e.year)));
         chk("year_7seg", 32'(bus.year_7seg), 32'(yseg(e.year)));
         chk("leap", 32'(bus.leap), 32'(is_leap(e.year)));
         chk("carry_out", 32'(bus.carry_out), 32'(e.cout));
         chk("load_err", 32'(bus.load_err), 32'(e.lerr));
      end
   end

   task automatic ldc(input logic [15:0] b);
      step(1, 0, 0, 4'h0, 1, b);
      step(1, 1, 0, 4'h0, 0, 16'h0);
      step(1, 0, 0, 4'h0, 0, 16'h0);
   endtask

   task automatic press(input logic [3:0] u);
      step(1, 0, 1, u, 0, 16'h0);
      step(1, 0, 1, 4'h0, 0, 16'h0);
   endtask

   initial begin
      logic [15:0] lb;
      int r;
      total = 0;
      bad = 0;
      rst_n = 1'b0;
      bus.carry_in = 1'b0;
      bus.set = 1'b0;
      bus.up = 4'hF;
      bus.load = 1'b0;
      bus.load_bcd = 16'h0;
      step(0, 0, 0, 4'hF, 0, 16'h0);
      step(0, 0, 0, 4'hF, 0, 16'h0);
      repeat (5) step(1, 0, 1, 4'hF, 0, 16'h0);
      step(1, 0, 0, 4'h0, 0, 16'h0);
      ldc(16'h2199);
      ldc(16'h1899);
      ldc(16'h1999);
      ldc(16'h2023);
      step(1, 0, 0, 4'h0, 1, 16'h1801);
      repeat (9) press(4'h1);
      press(4'h8);
      step(1, 1, 1, 4'h0, 0, 16'h0);
      step(1, 1, 1, 4'h0, 0, 16'h0);
      press(4'h6);
      step(1, 0, 0, 4'h0, 0, 16'h0);
      step(1, 0, 0, 4'h0, 1, 16'h19A0);
      step(1, 0, 0, 4'h0, 1, 16'h2500);
      step(1, 1, 0, 4'h0, 1, 16'h2000);
      step(1, 1, 0, 4'h0, 0, 16'h0);
      step(1, 1, 0, 4'h0, 0, 16'h0);
      step(0, 1, 0, 4'h0, 1, 16'h2000);
      step(1, 0, 0, 4'h0, 0, 16'h0);
      for (int k = 0; k < 3000; k++) begin
         r = $urandom_range(0, 99);
         if ($urandom_range(0, 1) == 1)
            lb = ybcd($urandom_range(YMIN - 50, YMAX + 50));
         else
            lb = 16'($urandom);
         step(r != 0, $urandom_range(0, 2) != 0,
              $urandom_range(0, 3) == 0, 4'($urandom),
              $urandom_range(0, 15) == 0, lb);
      end
      for (int k = 0; k < 5 && sbq.size() != 0; k++) @(negedge clk);
      chk("drain", 32'(sbq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/year_bcd_counter.md
# year_bcd_counter

Parametrised, fully synchronous BCD year counter for the calendar datapath. It advances on a one-cycle carry pulse from the month stage and wraps within a programmable year range. It supports per-digit manual adjustment in set mode and a validated parallel load, and provides binary, BCD, 7-segment and leap-year outputs to the display and day-of-month logic.

## Interface
- DIGITS, 4: number of BCD digits (2..4).
- BIN_BITS, 14: width of binary year output; must hold 10^DIGITS-1.
- YEAR_MIN, 1800: lowest legal year (binary).
- YEAR_MAX, 2199: highest legal year; YEAR_MIN < YEAR_MAX < 10^DIGITS.
- YEAR_RESET, 1801: value after reset; YEAR_MIN ≤ YEAR_RESET ≤ YEAR_MAX.

- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-low reset.
- carry_in  input  1  one-cycle pulse from the month counter; increments the year when not in set mode.
- set  input  1  set mode (switch level); 1 = manual adjust, carry_in ignored.
- up  input  DIGITS  per-digit adjust buttons (levels); bit i adjusts digit i (0 = ones).
- load  input  1  one-cycle parallel load strobe.
- load_bcd  input  4*DIGITS  BCD year to load.
- year_count  output  BIN_BITS  binary year.
- year_bcd  output  4*DIGITS  BCD digits, digit i at [4i+3:4i].
- year_7seg  output  7*DIGITS  7-segment pattern per digit, digit i at [7i+6:7i], same encoding as the existing bcd_to_7segment.
- leap  output  1  1 when the current year is a Gregorian leap year.
- carry_out  output  1  one-cycle pulse on YEAR_MAX→YEAR_MIN wrap.
- load_err  output  1  one-cycle pulse when a load is rejected.

## Operation
- State: DIGITS BCD digit registers, up_q edge-detect register (DIGITS bits), carry_out and load_err registers.
- No derived clocks. Button edges are detected synchronously: rise[i] = up[i] & ~up_q[i]; up_q <= up every cycle.
- Per-cycle priority: reset > load > set-mode adjust > carry_in increment.
- Reset (reset=0 at an edge):
  - digits <= BCD(YEAR_RESET).
  - up_q <= all ones, so a button held through reset generates no edge.
  - carry_out <= 0; load_err <= 0.
- Load (load=1), valid only if every nibble of load_bcd is ≤ 9 and its value is in [YEAR_MIN, YEAR_MAX]:
  - Valid: digits <= load_bcd.
  - Invalid: state unchanged and load_err pulses.
  - Load is accepted in either mode. A carry_in or button edge in the same cycle is dropped.
- Set mode (set=1):
  - Each digit with rise[i]=1 increments modulo 10 (9→0) with no carry into digit i+1.
  - Simultaneous edges on several digits are all applied in the same cycle.
  - If the resulting candidate is outside [YEAR_MIN, YEAR_MAX], digits <= BCD(YEAR_MIN).
  - carry_in is discarded; carry_out stays 0.
- Run mode (set=0):
  - Edges on up are ignored; up_q still tracks up.
  - On carry_in=1, if year == YEAR_MAX: digits <= BCD(YEAR_MIN) and carry_out <= 1.
  - Otherwise, BCD ripple increment (a 9 in any digit becomes 0 and carries into the next digit).
- Outputs are combinational from the digit registers:
  - year_count = Σ digit_i·10^i, zero-extended/truncated to BIN_BITS.
  - year_7seg = per-digit decode of year_bcd.
  - leap = div4 & (~div100 | div400). Computed from BCD: the two low digits form a multiple of 4; div100 = both low digits are 0; div400 = div100 and the upper two digits form a multiple of 4. For DIGITS=2 the upper digits are treated as 0.

## Timing
- Latency: carry_in, load or a button edge at edge N updates digits and all outputs after edge N. carry_out and load_err are high for exactly the cycle following edge N.
- A button press is seen one cycle after it is sampled high, and only once per press regardless of how long it is held.
- Back-to-back carry_in pulses increment once per cycle.
- Leaving set mode does not replay dropped carries.
- Reset asserted mid-operation overrides everything at that edge. Outputs show YEAR_RESET values from the next cycle: year_count=1801, year_bcd=16'h1801, leap=0, carry_out=0, load_err=0.

## Test plan
- Reset with up held high, release reset, hold up 5 cycles → year_count=1801, leap=0, no digit change.
- Load 16'h2199, set=0, one carry_in pulse → year_bcd=16'h1800, carry_out=1 for one cycle, leap=0. Load 16'h1899, carry_in → 16'h1900, leap=0.
- Load 16'h1999, carry_in → 16'h2000, year_count=2000, leap=1. Load 16'h2023, carry_in → 2024, leap=1.
- set=1, year 1801: press up[0] 9 times → 1800 (no carry). Press up[3] → candidate 2800 > 2199, so the year becomes 1800. carry_in pulses during set mode leave the year unchanged.
- Loads of 16'h19A0 and 16'h2500 → load_err pulses, state unchanged. Load and carry_in in the same cycle with 16'h2000 → year=2000, not 2001.
- Apply reset at the same edge as load and carry_in → year=1801, both pulses low.
